// File: rtl/im_loader.sv
// -----------------------------------------------------------------------------
// im_loader
//   Byte-stream bootloader for the 16-bit instruction memory. A frame is:
//     SYNC_BYTE, len[15:8], len[7:0], len big-endian 16-bit words, checksum
//   where checksum is the XOR of all data bytes. Each assembled word is written
//   to IM at BASE_ADDR + index (mod 2**ADDR_W). The CPU is held in reset until
//   a frame with a good checksum has been loaded.
//
// Ports
//   clk        system clock, all state on posedge
//   rst        asynchronous reset, active-high
//   rx_data    incoming byte
//   rx_vld     rx_data valid; a byte is consumed when rx_vld & rx_rdy
//   rx_rdy     loader can accept a byte (low only in DONE / ERR)
//   restart    1-cycle pulse: leave DONE / ERR and return to IDLE
//   im_we      IM write strobe, one cycle per word
//   im_addr    IM word address (upper 16-ADDR_W bits always 0)
//   im_wdata   IM write data
//   cpu_hold   holds the processor in reset while loading
//   load_done  image loaded with good checksum (level)
//   load_err   framing / length / checksum error (level)
// -----------------------------------------------------------------------------
module im_loader #(
   parameter int         ADDR_W    = 11,
   parameter logic [7:0] SYNC_BYTE = 8'hA5,
   parameter int         BASE_ADDR = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_vld,
   output logic        rx_rdy,
   input  logic        restart,
   output logic        im_we,
   output logic [15:0] im_addr,
   output logic [15:0] im_wdata,
   output logic        cpu_hold,
   output logic        load_done,
   output logic        load_err
);

   typedef enum logic [2:0] {
      IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, CHK, DONE, ERR
   } state_t;

   // Largest legal length is the full IM depth; 17 bits so it fits for ADDR_W=16.
   localparam logic [16:0] MAX_LEN = 17'(2 ** ADDR_W);

   state_t            state, state_nxt;
   logic [15:0]       len, len_nxt;
   logic [15:0]       count, count_nxt;
   logic [ADDR_W-1:0] ptr, ptr_nxt;
   logic [7:0]        hi, hi_nxt;
   logic [7:0]        csum, csum_nxt;
   logic              rx_rdy_nxt, im_we_nxt, cpu_hold_nxt;
   logic              load_done_nxt, load_err_nxt;
   logic [15:0]       im_addr_nxt, im_wdata_nxt;
   logic              beat;

   // rx_rdy is registered from the state, so a beat can only occur in IDLE..CHK.
   assign beat = rx_vld & rx_rdy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         len       <= '0;
         count     <= '0;
         ptr       <= '0;
         hi        <= '0;
         csum      <= '0;
         rx_rdy    <= 1'b1;
         im_we     <= 1'b0;
         im_addr   <= '0;
         im_wdata  <= '0;
         cpu_hold  <= 1'b1;
         load_done <= 1'b0;
         load_err  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values computed by the combinational block.
         state     <= state_nxt;
         len       <= len_nxt;
         count     <= count_nxt;
         ptr       <= ptr_nxt;
         hi        <= hi_nxt;
         csum      <= csum_nxt;
         rx_rdy    <= rx_rdy_nxt;
         im_we     <= im_we_nxt;
         im_addr   <= im_addr_nxt;
         im_wdata  <= im_wdata_nxt;
         cpu_hold  <= cpu_hold_nxt;
         load_done <= load_done_nxt;
         load_err  <= load_err_nxt;
      end
   end

   always_comb begin
      // NOTE: every signal gets a default before the case so no path can
      // leave one unassigned and infer a latch.
      state_nxt     = state;
      len_nxt       = len;
      count_nxt     = count;
      ptr_nxt       = ptr;
      hi_nxt        = hi;
      csum_nxt      = csum;
      im_we_nxt     = 1'b0;
      im_addr_nxt   = im_addr;
      im_wdata_nxt  = im_wdata;
      cpu_hold_nxt  = cpu_hold;
      load_done_nxt = load_done;
      load_err_nxt  = load_err;

      case (state)
         IDLE: begin
            if (beat && rx_data == SYNC_BYTE) begin
               // New frame: previous status is discarded, CPU held again.
               state_nxt     = LEN_HI;
               load_done_nxt = 1'b0;
               load_err_nxt  = 1'b0;
               cpu_hold_nxt  = 1'b1;
            end
         end
         LEN_HI: begin
            if (beat) begin
               len_nxt   = {rx_data, len[7:0]};
               state_nxt = LEN_LO;
            end
         end
         LEN_LO: begin
            if (beat) begin
               len_nxt   = {len[15:8], rx_data};
               // Cleared on both the data and the empty-image path so an
               // empty image expects a checksum of 8'h00.
               count_nxt = '0;
               csum_nxt  = '0;
               ptr_nxt   = ADDR_W'(BASE_ADDR);
               if ({1'b0, len_nxt} > MAX_LEN)
                  state_nxt = ERR;
               else if (len_nxt == 16'd0)
                  state_nxt = CHK;
               else
                  state_nxt = DAT_HI;
            end
         end
         DAT_HI: begin
            if (beat) begin
               hi_nxt    = rx_data;
               csum_nxt  = csum ^ rx_data;
               state_nxt = DAT_LO;
            end
         end
         DAT_LO: begin
            if (beat) begin
               csum_nxt     = csum ^ rx_data;
               im_we_nxt    = 1'b1;
               im_wdata_nxt = {hi, rx_data};
               im_addr_nxt  = 16'(ptr);
               // ptr is ADDR_W wide, so the increment wraps modulo the depth.
               ptr_nxt      = ptr + ADDR_W'(1);
               count_nxt    = count + 16'd1;
               state_nxt    = (count_nxt == len) ? CHK : DAT_HI;
            end
         end
         CHK: begin
            if (beat)
               state_nxt = (rx_data == csum) ? DONE : ERR;
         end
         DONE, ERR: begin
            if (restart)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      // Status levels change only on entry to DONE / ERR; a restart back to
      // IDLE leaves them untouched until the next sync byte.
      if (state_nxt == DONE && state != DONE) begin
         load_done_nxt = 1'b1;
         cpu_hold_nxt  = 1'b0;
      end
      if (state_nxt == ERR && state != ERR) begin
         load_err_nxt = 1'b1;
         cpu_hold_nxt = 1'b1;
      end

      rx_rdy_nxt = !(state_nxt == DONE || state_nxt == ERR);
   end

endmodule

// File: tb/tb_im_loader.sv
// -----------------------------------------------------------------------------
// tb_im_loader
//   Two loaders share one byte stream: one with BASE_ADDR=0 and one with
//   BASE_ADDR=2047, so every frame also exercises address wrap. Expected IM
//   writes are derived per frame from the frame contents (address = base +
//   word index mod 2048) and queued; a compare process pops one entry for
//   every im_we it sees. Frame status is compared once the last byte settles.
// -----------------------------------------------------------------------------
module tb_im_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_vld = 1'b0;
   logic        restart = 1'b0;

   logic        rx_rdy0, im_we0, cpu_hold0, load_done0, load_err0;
   logic [15:0] im_addr0, im_wdata0;
   logic        rx_rdy1, im_we1, cpu_hold1, load_done1, load_err1;
   logic [15:0] im_addr1, im_wdata1;

   int tests = 0;
   int fails = 0;
   int max_gap = 0;
   bit noisy = 1'b0;

   logic [31:0] q0[$], q1[$];       // expected {addr, data} writes
   logic [31:0] obs0[$], obs1[$];   // observed writes, for literal pinning
   logic [15:0] words[$];

   im_loader #(.ADDR_W(11), .SYNC_BYTE(8'hA5), .BASE_ADDR(0)) dut0 (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_vld(rx_vld), .rx_rdy(rx_rdy0),
      .restart(restart), .im_we(im_we0), .im_addr(im_addr0), .im_wdata(im_wdata0),
      .cpu_hold(cpu_hold0), .load_done(load_done0), .load_err(load_err0));

   im_loader #(.ADDR_W(11), .SYNC_BYTE(8'hA5), .BASE_ADDR(2047)) dut1 (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_vld(rx_vld), .rx_rdy(rx_rdy1),
      .restart(restart), .im_we(im_we1), .im_addr(im_addr1), .im_wdata(im_wdata1),
      .cpu_hold(cpu_hold1), .load_done(load_done1), .load_err(load_err1));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   // Per-cycle write comparison, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (im_we0) begin
            if (q0.size() == 0) check("unexpected_we0", {im_addr0, im_wdata0}, 32'hxxxx_xxxx);
            else check("write0", {im_addr0, im_wdata0}, q0.pop_front());
            obs0.push_back({im_addr0, im_wdata0});
         end
         if (im_we1) begin
            if (q1.size() == 0) check("unexpected_we1", {im_addr1, im_wdata1}, 32'hxxxx_xxxx);
            else check("write1", {im_addr1, im_wdata1}, q1.pop_front());
            obs1.push_back({im_addr1, im_wdata1});
         end
      end
   end

   task automatic push_word(input int i, input logic [15:0] w);
      q0.push_back({16'((0 + i) % 2048), w});
      q1.push_back({16'((2047 + i) % 2048), w});
   endtask

   // Called just after a posedge; returns just after the posedge that took the byte.
   task automatic send_byte(input logic [7:0] b);
      repeat ($urandom_range(max_gap, 0)) begin
         @(posedge clk);
         #1;
      end
      rx_data = b;
      rx_vld  = 1'b1;
      if (noisy && $urandom_range(3, 0) == 0) restart = 1'b1;
      @(posedge clk);
      #1;
      rx_vld  = 1'b0;
      restart = 1'b0;
   endtask

   task automatic check_levels(input string tag, input bit ok, input bit rdy);
      check({tag, "_done0"}, 32'(load_done0), 32'(ok));
      check({tag, "_err0"},  32'(load_err0),  32'(!ok));
      check({tag, "_hold0"}, 32'(cpu_hold0),  32'(!ok));
      check({tag, "_rdy0"},  32'(rx_rdy0),    32'(rdy));
      check({tag, "_done1"}, 32'(load_done1), 32'(ok));
      check({tag, "_err1"},  32'(load_err1),  32'(!ok));
      check({tag, "_hold1"}, 32'(cpu_hold1),  32'(!ok));
      check({tag, "_rdy1"},  32'(rx_rdy1),    32'(rdy));
   endtask

   task automatic restart_pulse(input string tag, input bit ok);
      restart = 1'b1;
      @(posedge clk);
      #1;
      restart = 1'b0;
      @(negedge clk);
      check_levels({tag, "_restart"}, ok, 1'b1);
      @(posedge clk);
      #1;
   endtask

   // Sends garbage, sync, length and (if legal) words[0..n-1] plus checksum
   // XOR-ed with sum_xor; returns whether the frame must load successfully.
   task automatic send_frame(input string tag, input int n, input logic [7:0] sum_xor,
                             input int garbage, output bit ok);
      logic [7:0]  cs;
      logic [7:0]  b;
      logic [15:0] w;
      cs = 8'h00;
      for (int g = 0; g < garbage; g++) begin
         b = 8'($urandom);
         if (b == 8'hA5) b = 8'h3C;
         send_byte(b);
      end
      send_byte(8'hA5);
      @(negedge clk);
      check({tag, "_sync_err0"},  32'(load_err0),  32'd0);
      check({tag, "_sync_done0"}, 32'(load_done0), 32'd0);
      check({tag, "_sync_hold0"}, 32'(cpu_hold0),  32'd1);
      @(posedge clk);
      #1;
      send_byte(8'(n >> 8));
      send_byte(8'(n));
      if (n > 2048) begin
         ok = 1'b0;
      end else begin
         for (int i = 0; i < n; i++) begin
            w = words[i];
            send_byte(w[15:8]);
            push_word(i, w);
            send_byte(w[7:0]);
            cs = cs ^ w[15:8] ^ w[7:0];
         end
         send_byte(cs ^ sum_xor);
         ok = (sum_xor == 8'h00);
      end
      repeat (2) @(negedge clk);
      check({tag, "_pending0"}, 32'(q0.size()), 32'd0);
      check({tag, "_pending1"}, 32'(q1.size()), 32'd0);
      check_levels(tag, ok, 1'b0);
      @(posedge clk);
      #1;
   endtask

   task automatic set_t1_words();
      words.delete();
      words.push_back(16'h1234);
      words.push_back(16'hABCD);
   endtask

   initial begin
      bit ok;
      int n;
      logic [7:0] sx;

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("reset_rdy",   32'(rx_rdy0),    32'd1);
      check("reset_we",    32'(im_we0),     32'd0);
      check("reset_addr",  32'(im_addr0),   32'd0);
      check("reset_wdata", 32'(im_wdata0),  32'd0);
      check("reset_hold",  32'(cpu_hold0),  32'd1);
      check("reset_done",  32'(load_done0), 32'd0);
      check("reset_err",   32'(load_err0),  32'd0);
      @(posedge clk);
      #1;

      // Frame A5 00 02 12 34 AB CD 40, with literal writes pinning the model.
      set_t1_words();
      obs0.delete();
      obs1.delete();
      send_frame("t1", 2, 8'h00, 0, ok);
      check("t1_ok_literal", 32'(ok), 32'd1);
      check("t1_nwr0", 32'(obs0.size()), 32'd2);
      check("t1_nwr1", 32'(obs1.size()), 32'd2);
      if (obs0.size() == 2) begin
         check("t1_w0_lit", obs0[0], 32'h0000_1234);
         check("t1_w1_lit", obs0[1], 32'h0001_ABCD);
      end
      if (obs1.size() == 2) begin
         check("t1_wrap_w0_lit", obs1[0], 32'h07FF_1234);
         check("t1_wrap_w1_lit", obs1[1], 32'h0000_ABCD);
      end

      // Bytes offered while rx_rdy=0 are not consumed.
      send_byte(8'hA5);
      send_byte(8'h00);
      @(negedge clk);
      check_levels("t1_blocked", 1'b1, 1'b0);
      @(posedge clk);
      #1;
      restart_pulse("t1", 1'b1);

      // Same frame with checksum 41.
      send_frame("t2", 2, 8'h01, 0, ok);
      restart_pulse("t2", 1'b0);

      // Leading garbage then a good frame.
      obs0.delete();
      send_frame("t3", 2, 8'h00, 3, ok);
      check("t3_nwr0", 32'(obs0.size()), 32'd2);
      restart_pulse("t3", 1'b1);

      // Length 2049 is rejected right after the length bytes.
      send_frame("t4", 2049, 8'h00, 0, ok);
      restart_pulse("t4", 1'b0);

      // Empty image with checksum 00.
      send_frame("t5", 0, 8'h00, 0, ok);
      restart_pulse("t5", 1'b1);

      // Asynchronous reset in the middle of the second word.
      send_byte(8'hA5);
      send_byte(8'h00);
      send_byte(8'h02);
      send_byte(8'h12);
      push_word(0, 16'h1234);
      send_byte(8'h34);
      send_byte(8'hAB);
      #2;
      rst = 1'b1;
      #1;
      check("t6_rst_rdy",   32'(rx_rdy0),    32'd1);
      check("t6_rst_we",    32'(im_we0),     32'd0);
      check("t6_rst_addr",  32'(im_addr0),   32'd0);
      check("t6_rst_wdata", 32'(im_wdata0),  32'd0);
      check("t6_rst_hold",  32'(cpu_hold0),  32'd1);
      check("t6_rst_done",  32'(load_done0), 32'd0);
      check("t6_rst_err",   32'(load_err0),  32'd0);
      check("t6_pending0",  32'(q0.size()),  32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      send_byte(8'hCD);   // stray byte in IDLE must not produce a write
      repeat (3) @(negedge clk);
      check("t6_after_hold", 32'(cpu_hold0), 32'd1);
      @(posedge clk);
      #1;

      // Tests 1-2 again with idle gaps and ignored restart pulses.
      max_gap = 5;
      noisy   = 1'b1;
      set_t1_words();
      send_frame("t6_gap_ok", 2, 8'h00, 0, ok);
      noisy = 1'b0;
      restart_pulse("t6_gap_ok", 1'b1);
      noisy = 1'b1;
      send_frame("t6_gap_bad", 2, 8'h01, 0, ok);
      noisy = 1'b0;
      restart_pulse("t6_gap_bad", 1'b0);

      // Randomized frames.
      for (int f = 0; f < 40; f++) begin
         n = $urandom_range(8, 0);
         words.delete();
         for (int i = 0; i < n; i++) words.push_back(16'($urandom));
         sx = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
         noisy = 1'b1;
         send_frame("rand", n, sx, $urandom_range(3, 0), ok);
         noisy = 1'b0;
         restart_pulse("rand", ok);
      end

      // Full-depth image: every address written, both bases wrap.
      max_gap = 0;
      words.delete();
      for (int i = 0; i < 2048; i++) words.push_back(16'($urandom));
      obs0.delete();
      send_frame("full", 2048, 8'h00, 0, ok);
      check("full_nwr0", 32'(obs0.size()), 32'd2048);
      if (obs0.size() == 2048) check("full_last_addr", 32'(obs0[2047][31:16]), 32'd2047);
      restart_pulse("full", 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
